fp_ext_unit: RTL and testbench

Floating-point operand unpacker for the FPU front end. Takes a raw FP32 (NaN-boxing ignored, low 32 bits used) or FP64 operand and produces a 65-bit internal extended format: 1 sign, 12-bit exponent, 52-bit fraction, with subnormals normalized. It also produces the 10-bit RISC-V FCLASS one-hot classification. Leading-zero counting is done by an external shared 64-bit LZC, reached through a request/return port pair.

---
 rtl/fp_ext_pkg.sv | 33 +++
 rtl/fp_ext_unit.sv | 117 +++++++++++
 tb/tb_fp_ext_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fp_ext_pkg.sv
// Shared FPU constants: FCLASS bit indices, operand format encodings,
// exponent rebias offsets and the packed extended-operand layout.
package fp_ext_pkg;

  // RISC-V FCLASS one-hot bit positions
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  // operand formats (2/3 reserved)
  localparam logic [1:0] FMT_FP32 = 2'd0;
  localparam logic [1:0] FMT_FP64 = 2'd1;

  // rebias into the 12-bit internal exponent (internal bias 2047)
  localparam logic [11:0] BIAS_S_NORM = 12'h780;
  localparam logic [11:0] BIAS_S_SUB  = 12'h781;
  localparam logic [11:0] BIAS_D_NORM = 12'h400;
  localparam logic [11:0] BIAS_D_SUB  = 12'h401;

  typedef struct packed {
    logic        sign;
    logic [11:0] exp;
    logic [51:0] frac;
  } fp_ext_t;

endpackage

// File: rtl/fp_ext_unit.sv
// FP operand unpacker: FP32/FP64 -> 65-bit {sign, exp[11:0], frac[51:0]}
// with subnormals normalized, plus the 10-bit FCLASS one-hot.
// Ports:
//   fp_ext_i_clk / fp_ext_i_rst_n  clock, async active-low reset
//   fp_ext_i_data[63:0]            operand (FP32 in [31:0])
//   fp_ext_i_fmt[1:0]              0=FP32, 1=FP64, 2/3 reserved
//   lzc_i_a[63:0]                  comb operand to the shared external LZC
//   lzc_o_c[5:0]                   LZC return (inverted leading-zero count)
//   fp_ext_o_result[64:0]          registered extended operand
//   fp_ext_o_classification[9:0]   registered FCLASS one-hot
module fp_ext_unit
  import fp_ext_pkg::*;
(
  input  logic        fp_ext_i_clk,
  input  logic        fp_ext_i_rst_n,
  input  logic [63:0] fp_ext_i_data,
  input  logic [1:0]  fp_ext_i_fmt,
  output logic [63:0] lzc_i_a,
  input  logic [5:0]  lzc_o_c,
  output logic [64:0] fp_ext_o_result,
  output logic [9:0]  fp_ext_o_classification
);

  logic [5:0]  cnt;
  logic [7:0]  e32;
  logic [22:0] f32, f32_sh;
  logic [10:0] e64;
  logic [51:0] f64, f64_sh;
  logic        e_ones, e_zero, m_zero;
  fp_ext_t     res;
  logic [9:0]  cls;

  assign e32 = fp_ext_i_data[30:23];
  assign f32 = fp_ext_i_data[22:0];
  assign e64 = fp_ext_i_data[62:52];
  assign f64 = fp_ext_i_data[51:0];

  // Top bit cleared and trailing ones padded so the count is 1 + lz(frac),
  // saturating at 24 / 53 for a zero fraction.
  assign lzc_i_a = (fp_ext_i_fmt == FMT_FP32) ? {1'b0, f32, 40'hFF_FFFF_FFFF}
                                              : {1'b0, f64, 11'h7FF};
  assign cnt     = ~lzc_o_c;

  // Shifting by 1 + lz pushes the leading one out of the fraction field.
  assign f32_sh = f32 << cnt;
  assign f64_sh = f64 << cnt;

  always_comb begin
    res = '0;
    case (fp_ext_i_fmt)
      FMT_FP32: begin
        res.sign = fp_ext_i_data[31];
        if (&e32) begin
          res.exp         = 12'hFFF;
          res.frac[51:29] = f32;
        end else if (|e32) begin
          res.exp         = {4'h0, e32} + BIAS_S_NORM;
          res.frac[51:29] = f32;
        end else if (cnt < 6'd24) begin
          res.exp         = BIAS_S_SUB - {6'd0, cnt};
          res.frac[51:29] = f32_sh;
        end
      end
      FMT_FP64: begin
        res.sign = fp_ext_i_data[63];
        if (&e64) begin
          res.exp  = 12'hFFF;
          res.frac = f64;
        end else if (|e64) begin
          res.exp  = {1'b0, e64} + BIAS_D_NORM;
          res.frac = f64;
        end else if (cnt < 6'd53) begin
          res.exp  = BIAS_D_SUB - {6'd0, cnt};
          res.frac = f64_sh;
        end
      end
      default: res = '0;
    endcase
  end

  // Reserved formats still classify from the FP64 fields, with sign 0.
  always_comb begin
    if (fp_ext_i_fmt == FMT_FP32) begin
      e_ones = &e32;
      e_zero = ~|e32;
      m_zero = ~|f32;
    end else begin
      e_ones = &e64;
      e_zero = ~|e64;
      m_zero = ~|f64;
    end
  end

  always_comb begin
    cls = '0;
    if (e_ones) begin
      if (m_zero) cls[res.sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
      else        cls[res.frac[51] ? CLS_QNAN : CLS_SNAN]   = 1'b1;
    end else if (e_zero) begin
      if (m_zero) cls[res.sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
      else        cls[res.sign ? CLS_NEG_SUB  : CLS_POS_SUB]  = 1'b1;
    end else begin
      cls[res.sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
    end
  end

  always_ff @(posedge fp_ext_i_clk or negedge fp_ext_i_rst_n) begin
    if (!fp_ext_i_rst_n) begin
      fp_ext_o_result         <= '0;
      fp_ext_o_classification <= '0;
    end else begin
      fp_ext_o_result         <= res;
      fp_ext_o_classification <= cls;
    end
  end

endmodule

// File: tb/tb_fp_ext_unit.sv
module tb_fp_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data = '0;
  logic [1:0]  fmt = '0;
  logic [63:0] lzc_a;
  logic [5:0]  lzc_c;
  logic [64:0] result;
  logic [9:0]  cls;
  int          checks = 0;
  int          failures = 0;
  int          lz_cnt;

  fp_ext_unit dut (
    .fp_ext_i_clk           (clk),
    .fp_ext_i_rst_n         (rst_n),
    .fp_ext_i_data          (data),
    .fp_ext_i_fmt           (fmt),
    .lzc_i_a                (lzc_a),
    .lzc_o_c                (lzc_c),
    .fp_ext_o_result        (result),
    .fp_ext_o_classification(cls)
  );

  always #5 clk = ~clk;

  // stand-in for the shared external LZC
  always_comb begin
    lz_cnt = 64;
    for (int i = 0; i < 64; i++) if (lzc_a[i]) lz_cnt = 63 - i;
  end
  assign lzc_c = ~lz_cnt[5:0];

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: decode the IEEE value, re-encode with internal bias 2047.
  function automatic void model(input logic [1:0] f, input logic [63:0] d,
                                output logic [64:0] r, output logic [9:0] c);
    logic        s, sp, quiet, sgn;
    int          e, emax, bias, fbits, p, ex;
    logic [63:0] fr, fa, tmp;
    logic [51:0] frac52;
    sp    = (f == 2'd0);
    fbits = sp ? 23 : 52;
    bias  = sp ? 127 : 1023;
    emax  = sp ? 255 : 2047;
    if (sp) begin s = d[31]; e = int'(d[30:23]); fr = {41'd0, d[22:0]}; end
    else    begin s = d[63]; e = int'(d[62:52]); fr = {12'd0, d[51:0]}; end
    ex = 0; fa = '0;
    if (e == emax) begin ex = 4095; fa = fr; end
    else if (e != 0) begin ex = e - bias + 2047; fa = fr; end
    else if (fr != 0) begin
      p = 0;
      for (int i = 0; i < 52; i++) if (fr[i]) p = i;
      ex = (p - (bias - 1) - fbits) + 2047;
      fa = (fr - (64'd1 << p)) << (fbits - p);
    end
    tmp    = fa << (52 - fbits);
    frac52 = tmp[51:0];
    r = (f <= 2'd1) ? {s, ex[11:0], frac52} : '0;
    sgn   = r[64];
    quiet = r[51];
    c = '0;
    if (e == emax)  c[(fr == 0) ? (sgn ? 0 : 7) : (quiet ? 9 : 8)] = 1'b1;
    else if (e == 0) c[(fr == 0) ? (sgn ? 3 : 4) : (sgn ? 2 : 5)] = 1'b1;
    else            c[sgn ? 1 : 6] = 1'b1;
  endfunction

  task automatic apply(input logic [1:0] f, input logic [63:0] d);
    @(negedge clk);
    fmt = f; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_model(input string tag, input logic [1:0] f, input logic [63:0] d);
    logic [64:0] er;
    logic [9:0]  ec;
    apply(f, d);
    model(f, d, er, ec);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cls"}, 65'(cls), 65'(ec));
  endtask

  function automatic logic [63:0] rnd_data(input logic [1:0] f);
    logic [63:0] d, fr;
    int kind;
    d    = {$urandom, $urandom};
    kind = $urandom_range(0, 5);
    fr   = {$urandom, $urandom} >> $urandom_range(0, 63);
    if (f == 2'd0) begin
      case (kind)
        0: d[30:0] = '0;
        1: begin d[30:23] = '0; d[22:0] = (fr[22:0] == 0) ? 23'd1 : fr[22:0]; end
        2: d[30:23] = 8'hFF;
        3: begin d[30:23] = 8'hFF; d[22:0] = '0; end
        4: d[30:23] = 8'd1 + 8'($urandom_range(0, 253));
        default: ;
      endcase
    end else begin
      case (kind)
        0: d[62:0] = '0;
        1: begin d[62:52] = '0; d[51:0] = (fr[51:0] == 0) ? 52'd1 : fr[51:0]; end
        2: d[62:52] = 11'h7FF;
        3: begin d[62:52] = 11'h7FF; d[51:0] = '0; end
        4: d[62:52] = 11'd1 + 11'($urandom_range(0, 2045));
        default: ;
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [1:0] f;
    #3;
    chk("rst_res", result, '0);
    chk("rst_cls", 65'(cls), '0);
    @(negedge clk) rst_n = 1'b1;

    apply(2'd0, 64'h3F80_0000);
    chk("sp_one_res", result, 65'h0_7FF0_0000_0000_0000);
    chk("sp_one_cls", 65'(cls), 65'(10'd1 << 6));
    apply(2'd0, 64'h0000_0001);
    chk("sp_minsub_res", result, 65'h0_76A0_0000_0000_0000);
    chk("sp_minsub_cls", 65'(cls), 65'(10'd1 << 5));
    apply(2'd1, 64'h7FF8_0000_0000_0000);
    chk("dp_qnan_res", result, 65'h0_FFF8_0000_0000_0000);
    chk("dp_qnan_cls", 65'(cls), 65'(10'd1 << 9));
    apply(2'd1, 64'h7FF0_0000_0000_0001);
    chk("dp_snan_cls", 65'(cls), 65'(10'd1 << 8));
    apply(2'd1, 64'h8000_0000_0000_0000);
    chk("dp_negz_res", result, 65'h1_0000_0000_0000_0000);
    chk("dp_negz_cls", 65'(cls), 65'(10'd1 << 3));
    apply(2'd1, 64'hFFF0_0000_0000_0000);
    chk("dp_neginf_cls", 65'(cls), 65'(10'd1 << 0));
    apply(2'd1, 64'h3FF0_0000_0000_0000);
    chk("dp_one_res", result, 65'h0_7FF0_0000_0000_0000);
    chk("dp_one_cls", 65'(cls), 65'(10'd1 << 6));
    apply(2'd2, 64'hBFF0_0000_0000_0000);
    chk("rsv_res", result, '0);
    chk("rsv_cls", 65'(cls), 65'(10'd1 << 6));
    apply(2'd0, 64'h0040_0000);
    chk("sp_maxsub_res", result, 65'h0_7800_0000_0000_0000);
    apply(2'd1, 64'h0000_0000_0000_0001);
    chk("dp_minsub_res", result, 65'h0_3CD0_0000_0000_0000);

    for (int n = 0; n < 3000; n++) begin
      f = 2'($urandom_range(0, 9) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1));
      apply_model("rand", f, rnd_data(f));
    end

    // reset mid-stream: outputs clear without waiting for a clock edge
    apply_model("pre_rst", 2'd1, 64'h3FF0_0000_0000_0000);
    @(negedge clk);
    fmt = 2'd0; data = 64'h0000_0000_C000_0000;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_res", result, '0);
    chk("midrst_cls", 65'(cls), '0);
    @(posedge clk); #1;
    chk("rst_hold_res", result, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_res", result, 65'h1_8000_0000_0000_0000);
    chk("post_rst_cls", 65'(cls), 65'(10'd1 << 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
